axi_stride_read_gen: RTL and testbench

Synthesizable AXI read-channel initiator (AR + R) that issues a programmed sequence of fixed-length INCR read bursts at a constant address stride and consumes and checks the returned data. It drives the prefetcher's slave read port (s_ar_*/s_r_*) in place of the accelerator, so strided traffic can be replayed in simulation and on FPGA. The block is the requester end of the same AR/R interface the prefetcher serves.

---
 rtl/axi_stride_read_gen.sv | 190 +++++++++++++++++++
 tb/tb_axi_stride_read_gen.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stride_read_gen.sv
// axi_stride_read_gen
//   AXI read-channel initiator (AR + R). Issues cfg_num_reqs INCR bursts of
//   cfg_len+1 beats at addresses cfg_base + k*cfg_stride (wrapping), keeps at
//   most MAX_OUTSTANDING bursts in flight, and consumes/checks returned data.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               run request, sampled only while idle
//   cfg_*               run configuration, latched on an accepted start
//   m_ar_*              AR channel towards the slave read port
//   m_r_*               R channel from the slave read port
//   busy, done          run in progress / one-cycle completion pulse
//   beat_cnt, checksum  accepted beats and their data sum for the run
//   err_last, err_id    sticky protocol error flags for the run
module axi_stride_read_gen #(
    parameter int ADDR_BITS       = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       cfg_base,
    input  logic [ADDR_BITS-1:0]       cfg_stride,
    input  logic [CNT_WIDTH-1:0]       cfg_num_reqs,
    input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
    input  logic [TID_WIDTH-1:0]       cfg_id,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [TID_WIDTH-1:0]       m_ar_id,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic                       m_r_last,
    input  logic [TID_WIDTH-1:0]       m_r_id,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       beat_cnt,
    output logic [DATA_WIDTH-1:0]      checksum,
    output logic                       err_last,
    output logic                       err_id
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [ADDR_BITS-1:0]       stride_q;
    logic [ADDR_BITS-1:0]       addr_q;
    logic [CNT_WIDTH-1:0]       num_q;
    logic [CNT_WIDTH-1:0]       issued_q;
    logic [BURST_LEN_WIDTH-1:0] len_q;
    logic [TID_WIDTH-1:0]       id_q;
    logic [OUT_W-1:0]           outst_q;
    logic [BURST_LEN_WIDTH-1:0] idx_q;
    logic [CNT_WIDTH-1:0]       beat_q;
    logic [DATA_WIDTH-1:0]      sum_q;
    logic                       err_last_q;
    logic                       err_id_q;

    logic can_issue;
    logic ar_hs;
    logic r_hs;
    logic r_retire;
    logic accept;

    // Issue eligibility depends only on registered state, so AR valid has no
    // combinational dependence on m_ar_ready.
    assign can_issue = (state == ISSUE) && (issued_q < num_q)
                       && (outst_q < OUT_W'(MAX_OUTSTANDING));
    assign ar_hs     = can_issue && m_ar_ready;
    assign r_hs      = m_r_valid && m_r_ready;
    assign r_retire  = r_hs && m_r_last;
    assign accept    = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        m_ar_valid = 1'b0;
        m_r_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (cfg_num_reqs == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy       = 1'b1;
                m_r_ready  = 1'b1;
                m_ar_valid = can_issue;
                if (ar_hs && (issued_q + CNT_WIDTH'(1) == num_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                m_r_ready = 1'b1;
                if (outst_q == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q   <= '0;
            addr_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            len_q      <= '0;
            id_q       <= '0;
            outst_q    <= '0;
            idx_q      <= '0;
            beat_q     <= '0;
            sum_q      <= '0;
            err_last_q <= 1'b0;
            err_id_q   <= 1'b0;
        end else begin
            if (accept) begin
                stride_q   <= cfg_stride;
                addr_q     <= cfg_base;
                num_q      <= cfg_num_reqs;
                len_q      <= cfg_len;
                id_q       <= cfg_id;
                issued_q   <= '0;
                outst_q    <= '0;
                idx_q      <= '0;
                beat_q     <= '0;
                sum_q      <= '0;
                err_last_q <= 1'b0;
                err_id_q   <= 1'b0;
            end

            if (ar_hs) begin
                addr_q   <= addr_q + stride_q;
                issued_q <= issued_q + CNT_WIDTH'(1);
            end

            if (r_hs) begin
                beat_q <= beat_q + CNT_WIDTH'(1);
                sum_q  <= sum_q + m_r_data;
                if ((idx_q == len_q) != m_r_last) begin
                    err_last_q <= 1'b1;
                end
                if (m_r_id != id_q) begin
                    err_id_q <= 1'b1;
                end
                idx_q <= m_r_last ? '0 : idx_q + BURST_LEN_WIDTH'(1);
            end

            // Simultaneous issue and retire leaves the in-flight count unchanged.
            case ({ar_hs, r_retire})
                2'b10:   outst_q <= outst_q + OUT_W'(1);
                2'b01:   outst_q <= outst_q - OUT_W'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    assign m_ar_addr = addr_q;
    assign m_ar_len  = len_q;
    assign m_ar_id   = id_q;
    assign beat_cnt  = beat_q;
    assign checksum  = sum_q;
    assign err_last  = err_last_q;
    assign err_id    = err_id_q;

endmodule

// File: tb/tb_axi_stride_read_gen.sv
// tb_axi_stride_read_gen
//   Drives axi_stride_read_gen with a randomised AR/R responder and compares
//   every cycle against a behavioural run model, plus literal expectations
//   for the directed scenarios.
module tb_axi_stride_read_gen;

    localparam int AW = 32;
    localparam int LW = 8;
    localparam int IW = 8;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_stride;
    logic [CW-1:0] cfg_num_reqs;
    logic [LW-1:0] cfg_len;
    logic [IW-1:0] cfg_id;
    logic          m_ar_valid;
    logic          m_ar_ready;
    logic [AW-1:0] m_ar_addr;
    logic [LW-1:0] m_ar_len;
    logic [IW-1:0] m_ar_id;
    logic          m_r_valid;
    logic          m_r_ready;
    logic [DW-1:0] m_r_data;
    logic          m_r_last;
    logic [IW-1:0] m_r_id;
    logic          busy;
    logic          done;
    logic [CW-1:0] beat_cnt;
    logic [DW-1:0] checksum;
    logic          err_last;
    logic          err_id;

    axi_stride_read_gen #(
        .ADDR_BITS      (AW),
        .BURST_LEN_WIDTH(LW),
        .TID_WIDTH      (IW),
        .DATA_WIDTH     (DW),
        .CNT_WIDTH      (CW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_base    (cfg_base),
        .cfg_stride  (cfg_stride),
        .cfg_num_reqs(cfg_num_reqs),
        .cfg_len     (cfg_len),
        .cfg_id      (cfg_id),
        .m_ar_valid  (m_ar_valid),
        .m_ar_ready  (m_ar_ready),
        .m_ar_addr   (m_ar_addr),
        .m_ar_len    (m_ar_len),
        .m_ar_id     (m_ar_id),
        .m_r_valid   (m_r_valid),
        .m_r_ready   (m_r_ready),
        .m_r_data    (m_r_data),
        .m_r_last    (m_r_last),
        .m_r_id      (m_r_id),
        .busy        (busy),
        .done        (done),
        .beat_cnt    (beat_cnt),
        .checksum    (checksum),
        .err_last    (err_last),
        .err_id      (err_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- responder controls ----------------
    int       ar_mode   = 1;    // 0: ready low, 1: ready high, 2: random
    int       r_prob    = 100;  // percent chance of presenting a beat
    int       r_hold    = 0;    // cycles before any beat may be presented
    int       last_at   = -1;   // >=0: assert RLAST on this beat index instead
    bit       bad_id    = 1'b0;
    bit       use_table = 1'b0;
    int       data_i    = 0;
    logic [7:0] dtab [3] = '{8'h01, 8'h02, 8'hFF};

    // ---------------- run model ----------------
    int            ph = 0;      // 0 idle, 1 running, 2 completion cycle
    logic [AW-1:0] mb = '0;
    logic [AW-1:0] ms = '0;
    int            mnum = 0, miss = 0, mout = 0, mlen = 0, midx = 0, mbeat = 0;
    logic [IW-1:0] mid = '0;
    logic [DW-1:0] msum = '0;
    bit            merrl = 1'b0, merri = 1'b0, mfresh = 1'b1;
    logic [AW-1:0] ar_log [$];
    int            ar_before_rlast = 0;
    bit            seen_rlast = 1'b0;

    // Responder: bursts are answered in order, one beat per granted cycle.
    initial begin
        int   rq [$];
        int   beat;
        bit   ar_hs_s, r_hs_s, r_last_s, rst_s;
        int   len_s;
        beat       = 0;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
        m_r_data   = '0;
        m_r_last   = 1'b0;
        m_r_id     = '0;
        forever begin
            @(negedge clk);
            ar_hs_s  = m_ar_valid && m_ar_ready;
            r_hs_s   = m_r_valid && m_r_ready;
            r_last_s = m_r_last;
            rst_s    = rst;
            len_s    = int'(m_ar_len);
            @(posedge clk);
            #1;
            if (rst_s) begin
                rq.delete();
                beat = 0;
            end else begin
                if (ar_hs_s) rq.push_back(len_s);
                if (r_hs_s) begin
                    data_i++;
                    if (r_last_s) begin
                        void'(rq.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
            if (r_hold > 0) r_hold--;
            case (ar_mode)
                0:       m_ar_ready = 1'b0;
                1:       m_ar_ready = 1'b1;
                default: m_ar_ready = 1'($urandom_range(1));
            endcase
            if (rq.size() > 0 && r_hold == 0 && int'($urandom_range(99)) < r_prob) begin
                m_r_valid = 1'b1;
                m_r_last  = (last_at >= 0) ? (beat == last_at) : (beat == rq[0]);
                m_r_id    = bad_id ? cfg_id + IW'(1) : cfg_id;
                m_r_data  = use_table ? dtab[data_i % 3] : DW'($urandom);
            end else begin
                m_r_valid = 1'b0;
                m_r_last  = 1'b0;
                m_r_data  = '0;
            end
        end
    end

    // Compare process: expected outputs for this cycle from the model, then
    // the model absorbs this cycle's handshakes.
    always @(negedge clk) begin
        bit            ev;
        bit            ar_hs;
        logic [AW-1:0] ea;
        ev = (ph == 1) && (miss < mnum) && (mout < MO);
        chk("ar_valid", m_ar_valid, ev);
        chk("r_ready", m_r_ready, ph == 1);
        chk("busy", busy, ph == 1);
        chk("done", done, ph == 2);
        if (ev) begin
            ea = mb + ms * AW'(miss);
            chk("ar_addr", m_ar_addr, ea);
            chk("ar_len", m_ar_len, LW'(mlen));
            chk("ar_id", m_ar_id, mid);
        end
        if (mfresh) begin
            chk("rst_ar_addr", m_ar_addr, 0);
            chk("rst_ar_len", m_ar_len, 0);
            chk("rst_ar_id", m_ar_id, 0);
        end
        chk("beat_cnt", beat_cnt, CW'(mbeat));
        chk("checksum", checksum, msum);
        chk("err_last", err_last, merrl);
        chk("err_id", err_id, merri);

        if (rst) begin
            ph = 0; mb = '0; ms = '0; mnum = 0; miss = 0; mout = 0; mlen = 0;
            midx = 0; mbeat = 0; mid = '0; msum = '0; merrl = 0; merri = 0;
            mfresh = 1;
        end else begin
            case (ph)
                0: if (start) begin
                    mb = cfg_base; ms = cfg_stride; mnum = int'(cfg_num_reqs);
                    mlen = int'(cfg_len); mid = cfg_id;
                    miss = 0; mout = 0; midx = 0; mbeat = 0; msum = '0;
                    merrl = 0; merri = 0; mfresh = 0;
                    ar_log.delete(); ar_before_rlast = 0; seen_rlast = 0;
                    ph = (cfg_num_reqs == 0) ? 2 : 1;
                end
                1: begin
                    if (miss == mnum && mout == 0) ph = 2;
                    ar_hs = ev && m_ar_ready;
                    if (ar_hs) begin
                        ar_log.push_back(m_ar_addr);
                        miss++;
                        mout++;
                        if (!seen_rlast) ar_before_rlast++;
                    end
                    if (m_r_valid) begin
                        mbeat++;
                        msum = msum + m_r_data;
                        if ((midx == mlen) != m_r_last) merrl = 1;
                        if (m_r_id != mid) merri = 1;
                        if (m_r_last) begin
                            midx = 0;
                            mout--;
                            seen_rlast = 1;
                        end else begin
                            midx++;
                        end
                    end
                end
                default: ph = 0;
            endcase
        end
    end

    task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input int n, input int l, input logic [IW-1:0] id);
        @(posedge clk);
        #1;
        cfg_base     = b;
        cfg_stride   = s;
        cfg_num_reqs = CW'(n);
        cfg_len      = LW'(l);
        cfg_id       = id;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk(name, got, 1);
    endtask

    task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] s,
                       input int n, input int l, input logic [IW-1:0] id, input string name);
        start_run(b, s, n, l, id);
        wait_done(name);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cfg_base     = '0;
        cfg_stride   = '0;
        cfg_num_reqs = '0;
        cfg_len      = '0;
        cfg_id       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ar_valid", m_ar_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_beat_cnt", beat_cnt, 0);

        // Basic stride, single-beat bursts.
        ar_mode = 1; r_prob = 100;
        run(32'h10, 32'h4, 3, 0, 8'd5, "t1_done");
        chk("t1_ar_count", ar_log.size(), 3);
        if (ar_log.size() >= 3) begin
            chk("t1_addr0", ar_log[0], 32'h10);
            chk("t1_addr1", ar_log[1], 32'h14);
            chk("t1_addr2", ar_log[2], 32'h18);
        end
        chk("t1_beat_cnt", beat_cnt, 3);
        chk("t1_err_last", err_last, 0);
        chk("t1_err_id", err_id, 0);

        // Outstanding limit while responses are held back.
        r_hold = 22;
        run(32'h100, 32'h40, 6, 1, 8'd5, "t2_done");
        chk("t2_ar_before_rlast", ar_before_rlast, 4);
        chk("t2_ar_count", ar_log.size(), 6);
        chk("t2_beat_cnt", beat_cnt, 12);

        // AR stalled for five cycles.
        ar_mode = 0;
        start_run(32'h200, 32'h8, 1, 0, 8'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", m_ar_valid, 1);
            chk("t3_stall_addr", m_ar_addr, 32'h200);
        end
        ar_mode = 1;
        wait_done("t3_done");
        chk("t3_ar_count", ar_log.size(), 1);

        // Early RLAST.
        last_at = 1;
        run(32'h300, 32'h10, 2, 2, 8'd5, "t4_done");
        chk("t4_err_last", err_last, 1);
        chk("t4_err_id", err_id, 0);
        chk("t4_beat_cnt", beat_cnt, 4);
        last_at = -1;

        // Wrong RID and wrapping checksum.
        bad_id = 1; use_table = 1; data_i = 0;
        run(32'h0, 32'h1, 3, 0, 8'd5, "t5_done");
        chk("t5_err_id", err_id, 1);
        chk("t5_err_last", err_last, 0);
        chk("t5_checksum", checksum, 8'h02);
        bad_id = 0; use_table = 0;

        // Reset in the middle of a run.
        ar_mode = 2; r_prob = 50;
        start_run(32'h400, 32'h20, 8, 3, 8'd7);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_ar_valid", m_ar_valid, 0);
        chk("t6_rst_r_ready", m_r_ready, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_beat_cnt", beat_cnt, 0);
        chk("t6_rst_addr", m_ar_addr, 0);

        // Zero-length run completes on the next cycle.
        ar_mode = 1; r_prob = 100;
        start_run(32'h500, 32'h4, 0, 0, 8'd5);
        @(negedge clk);
        chk("t6_num0_done", done, 1);
        chk("t6_num0_ar_valid", m_ar_valid, 0);
        chk("t6_num0_ar_count", ar_log.size(), 0);

        // Address accumulator wraps.
        run(32'hFFFF_FFFC, 32'h8, 2, 0, 8'd5, "t6_wrap_done");
        chk("t6_wrap_count", ar_log.size(), 2);
        if (ar_log.size() >= 2) chk("t6_wrap_addr1", ar_log[1], 32'h0000_0004);

        // Randomised runs.
        for (int r = 0; r < 12; r++) begin
            ar_mode = 2;
            r_prob  = int'($urandom_range(100, 30));
            r_hold  = int'($urandom_range(8));
            run($urandom, $urandom, int'($urandom_range(12, 1)), int'($urandom_range(3)),
                IW'($urandom), "rand_done");
            chk("rand_err_last", err_last, 0);
            chk("rand_err_id", err_id, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
